// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its latency timer.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MrIdle = 2'd0,
        MrWait = 2'd1,
        MrAck  = 2'd2
    } mr_state_e;

    localparam int unsigned MemClkDelay = 8;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned CntWidth    = 8;

endpackage

// File: rtl/mem_resp_timer.sv
// Loadable 8-bit down-counter with zero flag; stops at zero.
module mem_resp_timer
    import mem_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [CntWidth-1:0] load_val,
    output logic                zero
);

    logic [CntWidth-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Slow word-addressed RAM answering cs/we handshakes with a one-cycle ack after
// a fixed latency; the request is latched at acceptance and cs low aborts it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CLK_DELAY  = MemClkDelay
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DataWidth-1:0]  din,
    output logic [DataWidth-1:0]  dout,
    output logic                  ack,
    output logic                  busy
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    generate
        if (CLK_DELAY < 1 || CLK_DELAY > 255) begin : gen_bad_delay
            $error("mem_responder: CLK_DELAY must be within 1..255");
        end
    endgenerate

    mr_state_e             state_d, state_q;
    logic                  we_d, we_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DataWidth-1:0]  din_d, din_q;
    logic [DataWidth-1:0]  dout_d, dout_q;
    logic                  ack_d, ack_q;
    logic                  busy_d, busy_q;
    logic [DataWidth-1:0]  mem_q [Depth];

    logic mem_we;
    logic tmr_load;
    logic tmr_en;
    logic tmr_zero;

    mem_resp_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (CntWidth'(CLK_DELAY - 1)),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        dout_d   = dout_q;
        mem_we   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            MrIdle: begin
                if (cs) begin
                    state_d  = MrWait;
                    we_d     = we;
                    addr_d   = addr;
                    din_d    = din;
                    tmr_load = 1'b1;
                end
            end
            MrWait: begin
                // Dropping cs mid-wait abandons the request with no side effects.
                if (!cs) begin
                    state_d = MrIdle;
                end else if (tmr_zero) begin
                    state_d = MrAck;
                    if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d = mem_q[addr_q];
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            MrAck: begin
                state_d = MrIdle;
            end
            default: begin
                state_d = MrIdle;
            end
        endcase
        ack_d  = (state_d == MrAck);
        busy_d = (state_d != MrIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MrIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= din_q;
        end
    end

    assign dout = dout_q;
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache management unit's (cmu) miss/refill interface, i.e. the slave end of the cs/we/addr/din/dout/ack handshake.
- Models a slow word-addressed RAM with a fixed, parameterised access latency. It answers every accepted request with a one-cycle ack.
- Sits between a cmu instance and its backing storage. It is used both as the data RAM and, with writes unused, as the instruction store.

Parameters:
- ADDR_WIDTH, 5, word-address width; array depth = 2^ADDR_WIDTH words of 32 bits.
- CLK_DELAY, 8, cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- cs  input  1  request strobe from cmu; held high until ack.
- we  input  1  1 = write, 0 = read; sampled at acceptance.
- addr  input  ADDR_WIDTH  word address; sampled at acceptance.
- din  input  32  write data; sampled at acceptance.
- dout  output  32  read data; valid in the ack cycle, held until the next accepted read.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is outstanding (WAIT or ACK).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, ack=0, dout=0, busy=0, latched request cleared.
  - Memory array contents are NOT cleared.
  - Reset during WAIT aborts the request: no write, no ack.
- FSM states: IDLE, WAIT, ACK. All outputs are registered.
- IDLE:
  - cs=1 at edge E0 → latch we/addr/din, counter←CLK_DELAY-1, go WAIT, busy=1.
  - cs=0 → stay in IDLE.
- WAIT:
  - Each edge with cs=1: counter decrements.
  - counter==0 at the edge → go ACK. At that same edge:
    - read: dout←mem[addr_latched].
    - write: mem[addr_latched]←din_latched; dout unchanged.
  - cs=0 at any edge in WAIT → abort: go IDLE, busy=0, no write, no ack, dout unchanged.
  - Changes on addr/we/din during WAIT are ignored (latched values rule).
- ACK:
  - ack=1 for exactly one cycle.
  - ack is high in the cycle after edge E0+CLK_DELAY, so latency is CLK_DELAY edges from acceptance.
  - Next edge → IDLE unconditionally; ack=0, busy=0.
- Back-to-back:
  - cs still high on the IDLE cycle after ACK is accepted as a new request; this is how a cmu line refill proceeds word by word.
  - Minimum period: CLK_DELAY+2 cycles per word.
- Read-after-write to the same address in consecutive transactions returns the new data.
- CLK_DELAY=1: ack follows the edge right after acceptance (WAIT lasts one cycle).
- Counter width is 8 bits. CLK_DELAY outside 1..255 is a static configuration error and the elaboration check fails.
- No byte enables; full-word access only.
- cs=1 with ack high is not a new request. Acceptance occurs only in IDLE.

Decomposition:
- Shared constants in define.vh:
  - state encodings MR_IDLE=2'd0, MR_WAIT=2'd1, MR_ACK=2'd2.
  - default latency constant MEM_CLK_DELAY=8.
- One sub-module, mem_resp_timer: loadable 8-bit down-counter with load/enable/zero flag and asynchronous active-low clear, instantiated once.
- The storage array and FSM stay in mem_responder.

Test Plan:
1. Reset, then a read: preload mem[3]=32'hDEADBEEF, CLK_DELAY=8; cs=1, we=0, addr=3 accepted at E0 → ack high exactly in the cycle after E0+8, dout=32'hDEADBEEF, busy high during E0+1..E0+9, ack width 1.
2. Write then read: write addr=5, din=32'h12345678, then read addr=5 → second ack returns 32'h12345678. During the write, dout keeps its prior value.
3. Abort: accept a write to addr=7 (old 32'h0), drop cs at E0+4 → no ack ever, busy=0 next cycle; a later read of addr=7 returns 32'h0.
4. Burst: cs held high for 4 words, addr 8..11 changed right after each ack (memory preloaded 32'hA0..A3) → 4 acks spaced exactly CLK_DELAY+2=10 cycles, data 32'hA0, A1, A2, A3 in order.
5. Async reset mid-WAIT: rst_n low for half a cycle at E0+3 of a write to addr=2 → ack/busy/dout go 0 immediately; mem[2] unchanged; next request is served normally.
6. CLK_DELAY=1 build: read addr=0 → ack in the cycle after E0+1. Addr/din toggled during WAIT in the default build have no effect on the result.
